dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single synchronous-SRAM data port between two requesters:
//   - m0: the cpu32 memory stage.
//   - m1: a DMA/debug master.
//  Each requester uses a req/ack handshake. Read data returns one cycle after the accepted read,
//  tagged to its owner. Tie-breaking is round-robin with a bounded burst hold, or optional fixed m0 priority.
//  Sits between the core/DMA and the data SRAM (d_addr/d_data_w/d_data_we/d_data_r).
// PARAMETERS
//  MAX_BURST    4  consecutive grants the current owner may hold while the other master is requesting (legal 1..15)
//  M0_PRIORITY  0  1: m0 wins every conflict (MAX_BURST ignored); 0: round-robin with hold
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  reset       in   1   synchronous, active-high reset
//  m0_req      in   1   m0 requests an access this cycle
//  m0_we       in   1   1=write, 0=read
//  m0_addr     in   32  byte address
//  m0_wdata    in   32  write data
//  m0_ack      out  1   m0 access accepted this cycle (combinational)
//  m0_rvalid   out  1   m0 read data valid this cycle
//  m0_rdata    out  32  read data; qualify with m0_rvalid
//  m1_*        -    -   identical set for master 1
//  d_addr      out  32  SRAM address
//  d_data_w    out  32  SRAM write data
//  d_data_we   out  1   SRAM write enable
//  d_data_r    in   32  SRAM read data, valid the cycle after the address is presented
// BEHAVIOUR
//  State registers:
//   - last: owner of the most recent grant, 1 bit, reset 0.
//   - cnt: consecutive grants to last, 4 bits, reset 0.
//   - rd_pend: read in flight, reset 0.
//   - rd_own: owner of the in-flight read, reset 0.
//  Grant (combinational, once per cycle):
//   - reset=1: no grant.
//   - Only one req high: grant that master.
//   - Both high, M0_PRIORITY=1: grant m0.
//   - Both high, M0_PRIORITY=0: grant last if cnt<MAX_BURST, else grant the other master.
//  Grant output:
//   - mX_ack=1 for the granted master only; acks are never both high.
//   - An access completes in the cycle where req & ack. Unacked requesters hold req/we/addr/wdata stable.
//  SRAM drive, same cycle as the grant:
//   - d_addr/d_data_w/d_data_we come from the granted master.
//   - No grant: d_addr=0, d_data_w=0, d_data_we=0.
//  State update on grant g:
//   - g==last: cnt <= min(cnt+1, 15).
//   - g!=last: last <= g, cnt <= 1.
//   - No-grant cycle: cnt <= 0, last unchanged.
//  Read return:
//   - An accepted read sets rd_pend<=1, rd_own<=g; any other cycle sets rd_pend<=0.
//   - Next cycle: mX_rvalid = rd_pend & (rd_own==X).
//   - m0_rdata = m1_rdata = d_data_r (pass-through).
//   - Latency is exactly 1 cycle. Back-to-back reads give rvalid every cycle with no bubble,
//     including alternating owners.
//  Writes: d_data_we for one cycle; no rvalid.
//  Throughput: one access per cycle; no idle cycle inserted on owner switch.
//  Reset:
//   - All state clears.
//   - All acks, both rvalid, and d_data_we are 0 while reset=1 and in the first cycle after it.
//   - A read accepted the cycle before reset produces no rvalid.
//  Boundary conditions:
//   - cnt saturates at 15.
//   - MAX_BURST=1 gives strict alternation under continuous contention.
//   - A requester dropping req mid-burst frees the port immediately.
//   - A requester cannot be starved for more than MAX_BURST cycles (M0_PRIORITY=0).
// TESTING
//  1. After reset, m0 read 0x100 alone -> m0_ack same cycle, d_addr=0x100; next cycle m0_rvalid=1, m0_rdata=SRAM[0x100], m1_rvalid=0.
//  2. m1 write 0x200=0xDEADBEEF alone -> m1_ack, d_data_we=1 for one cycle; later m1 read 0x200 returns 0xDEADBEEF.
//  3. Both req continuously, MAX_BURST=4 -> grant pattern m0 x4, m1 x4, m0 x4...; never both acks; every read rvalid lands on its owner one cycle later.
//  4. MAX_BURST=1 contention, alternating reads of 0x0/0x4 -> rvalid alternates m0/m1 every cycle with no bubbles.
//  5. M0_PRIORITY=1, both req for 10 cycles -> m0_ack all 10; m1 acked on the first cycle m0_req=0.
//  6. Reset asserted the cycle after an m1 read is accepted -> no rvalid; acks=0 and d_data_we=0 during reset; m0 wins the first tie after reset.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory master of dmem_arbiter.
// Latency: n/a (wires only); read data is returned one cycle after the accepting ack.
// Backpressure: a requester holds req/we/addr/wdata stable until it sees ack.
//
// Signals:
//   req    master -> arbiter   access request
//   we     master -> arbiter   1=write, 0=read
//   addr   master -> arbiter   byte address
//   wdata  master -> arbiter   write data
//   ack    arbiter -> master   access accepted this cycle
//   rvalid arbiter -> master   read data valid this cycle
//   rdata  arbiter -> master   read data, qualified by rvalid
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single synchronous data SRAM port (cpu32 mem stage + DMA/debug).
// Latency: grant/ack and SRAM drive are combinational; read data returns exactly one cycle after the ack.
// Backpressure: a losing master simply sees no ack and must hold its request; one access per cycle, no switch bubble.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   m0, m1                requester bundles (req/we/addr/wdata in, ack/rvalid/rdata out)
//   d_addr, d_data_w      SRAM address and write data from the granted master (0 when idle)
//   d_data_we             SRAM write enable, one cycle per granted write
//   d_data_r              SRAM read data, valid the cycle after the address
module dmem_arbiter #(
   parameter int unsigned MAX_BURST   = 4,
   parameter bit          M0_PRIORITY = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave m0,
   dmem_arbiter_if.slave m1,
   output logic [31:0]   d_addr,
   output logic [31:0]   d_data_w,
   output logic          d_data_we,
   input  logic [31:0]   d_data_r
);

   localparam logic [3:0] MAX_BURST_W = 4'(MAX_BURST);
   localparam logic [3:0] CNT_MAX     = 4'd15;

   logic       last;
   logic [3:0] cnt;
   logic       rd_pend;
   logic       rd_own;
   // High for the first cycle after reset is released; grants are held off
   // for that one cycle so nothing reaches the SRAM before state has settled.
   logic       rst_hold;

   logic        gnt_vld;
   logic        gnt_id;
   logic        gnt_we;
   logic [31:0] gnt_addr;
   logic [31:0] gnt_wdata;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (!reset && !rst_hold) begin
         if (m0.req && m1.req) begin
            gnt_vld = 1'b1;
            if (M0_PRIORITY) begin
               gnt_id = 1'b0;
            end else if (cnt < MAX_BURST_W) begin
               // current owner still has burst budget left
               gnt_id = last;
            end else begin
               gnt_id = ~last;
            end
         end else if (m0.req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
         end else if (m1.req) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_we    = 1'b0;
      gnt_addr  = 32'h0;
      gnt_wdata = 32'h0;
      if (gnt_vld) begin
         if (gnt_id) begin
            gnt_we    = m1.we;
            gnt_addr  = m1.addr;
            gnt_wdata = m1.wdata;
         end else begin
            gnt_we    = m0.we;
            gnt_addr  = m0.addr;
            gnt_wdata = m0.wdata;
         end
      end
   end

   assign m0.ack    = gnt_vld & ~gnt_id;
   assign m1.ack    = gnt_vld &  gnt_id;

   assign d_addr    = gnt_addr;
   assign d_data_w  = gnt_wdata;
   assign d_data_we = gnt_we;

   // rd_pend is still set during the first reset cycle if a read was accepted
   // just before it; masking with reset kills that orphaned return.
   assign m0.rvalid = rd_pend & ~rd_own & ~reset;
   assign m1.rvalid = rd_pend &  rd_own & ~reset;
   assign m0.rdata  = d_data_r;
   assign m1.rdata  = d_data_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         last     <= 1'b0;
         cnt      <= 4'd0;
         rd_pend  <= 1'b0;
         rd_own   <= 1'b0;
         rst_hold <= 1'b1;
      end else begin
         rst_hold <= 1'b0;
         rd_pend  <= gnt_vld & ~gnt_we;
         if (gnt_vld && !gnt_we) begin
            rd_own <= gnt_id;
         end
         if (gnt_vld) begin
            if (gnt_id == last) begin
               cnt <= (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
            end else begin
               last <= gnt_id;
               cnt  <= 4'd1;
            end
         end else begin
            // an idle cycle ends the burst; the next tie goes back to last
            cnt <= 4'd0;
         end
      end
   end

endmodule
